// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
// Entries carry {pc, instr, misalign} from the fetch stage to the prefetch buffer.
package fetch_pkg;

  localparam int          FETCH_XLEN       = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] instr;
    logic                  misalign;
  } fetch_entry_t;

  typedef enum logic {
    FETCH_RUN  = 1'b0,
    FETCH_HALT = 1'b1
  } fetch_state_e;

  function automatic logic [FETCH_XLEN-1:0] pc_incr(input logic [FETCH_XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush and occupancy count.
// Push and pop in the same cycle are legal even when full.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage is data-only; occupancy is tracked by the control registers above.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: PC sequencing, one-cycle memory latency absorption, redirect flush.
// Optional FETCH_MISALIGN_CHECK_EN turns misaligned PCs into fault entries instead of forcing alignment.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            mem_req_o,
  output logic [XLEN-1:0] mem_addr_o,
  input  logic [XLEN-1:0] mem_rdata_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] out_instr_o,
  output logic [XLEN-1:0] out_pc_o,
  output logic            misalign_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = CW + 1;

`ifdef FETCH_MISALIGN_CHECK_EN
  localparam logic [XLEN-1:0] PC_MASK = '1;
`else
  localparam logic [XLEN-1:0] PC_MASK = {{(XLEN-2){1'b1}}, 2'b00};
`endif

  logic [XLEN-1:0] pc_p0;
  logic            inflight_p1;
  logic            inflight_mis_p1;
  logic [XLEN-1:0] inflight_pc_p1;
  fetch_state_e    state;
  fetch_state_e    state_next;

  logic [CW-1:0]   count;
  fetch_entry_t    head_entry;
  fetch_entry_t    push_entry;
  fetch_entry_t    out_entry;
  logic            bypass_valid;
  logic            out_valid;
  logic            pop;
  logic            fifo_pop;
  logic            push;
  logic [OW-1:0]   occupancy;
  logic            space;
  logic            attempt;
  logic            misaligned;
  logic            issue;
  logic            fault_issue;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_i),
    .push      (push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head      (head_entry),
    .count     (count)
  );

  // Stage p1 -> output: the returning read bypasses an empty buffer so data appears one cycle after issue.
  always_comb begin
    push_entry.pc       = inflight_pc_p1;
    push_entry.instr    = inflight_mis_p1 ? NOP_INSTR : mem_rdata_i;
    push_entry.misalign = inflight_mis_p1;

    bypass_valid = inflight_p1 && !redirect_i;
    out_valid    = (count != '0) || bypass_valid;
    out_entry    = (count != '0) ? head_entry : push_entry;

    pop      = out_valid && out_ready_i;
    fifo_pop = pop && (count != '0);
    push     = inflight_p1 && !(pop && (count == '0));

    occupancy = OW'(count) + OW'(inflight_p1) - OW'(pop);
    space     = occupancy < OW'(DEPTH);
    attempt   = rst_n && !redirect_i && space && (state == FETCH_RUN);
`ifdef FETCH_MISALIGN_CHECK_EN
    misaligned = (pc_p0[1:0] != 2'b00);
`else
    misaligned = 1'b0;
`endif
    issue       = attempt && !misaligned;
    fault_issue = attempt && misaligned;
  end

  always_comb begin
    mem_req_o   = issue;
    mem_addr_o  = pc_p0;
    out_valid_o = out_valid;
    out_instr_o = out_valid ? out_entry.instr : '0;
    out_pc_o    = out_valid ? out_entry.pc    : '0;
    misalign_o  = out_valid && out_entry.misalign;
  end

  // A misaligned fetch parks the controller until the next redirect.
  always_comb begin
    state_next = state;
    case (state)
      FETCH_RUN:  if (fault_issue) state_next = FETCH_HALT;
      FETCH_HALT: if (redirect_i)  state_next = FETCH_RUN;
      default:    state_next = FETCH_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= FETCH_RUN;
    else        state <= state_next;
  end

  // Stage p0 -> p1: PC advance and in-flight tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_p0           <= RESET_PC & PC_MASK;
      inflight_p1     <= 1'b0;
      inflight_mis_p1 <= 1'b0;
    end else if (redirect_i) begin
      pc_p0           <= redirect_pc_i & PC_MASK;
      inflight_p1     <= 1'b0;
      inflight_mis_p1 <= 1'b0;
    end else begin
      if (issue) pc_p0 <= pc_incr(pc_p0);
      inflight_p1     <= issue || fault_issue;
      inflight_mis_p1 <= fault_issue;
    end
  end

  always_ff @(posedge clk) begin
    if (issue || fault_issue) inflight_pc_p1 <= pc_p0;
  end

endmodule
